// File: rtl/in_fft_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// in_fft_fifo_ctrl_if
// Bundles the sample-source handshake, FIFO control/status, butterfly pair
// handshake and frame status of the input-FIFO frame sequencer.
//   master : used by the controller (drives strobes, mode, status)
//   slave  : used by the environment (source, FIFO, butterfly engine)
// Parameter FCW sets the FRAME_CNT width and must match the controller.
// -----------------------------------------------------------------------------
interface in_fft_fifo_ctrl_if #(
   parameter int FCW = 16
);
   logic           ABORT;
   logic           S_VALID;
   logic           S_READY;
   logic           FIFO_WR_FULL;
   logic           FIFO_R_EMPTY;
   logic           FIFO_WR_INC;
   logic           FIFO_R_INC;
   logic           FIFO_BLOCK;
   logic           FIFO_RST;
   logic           PAIR_READY;
   logic           PAIR_VALID;
   logic           FRAME_DONE;
   logic           BUSY;
   logic [FCW-1:0] FRAME_CNT;

   modport master (
      input  ABORT, S_VALID, FIFO_WR_FULL, FIFO_R_EMPTY, PAIR_READY,
      output S_READY, FIFO_WR_INC, FIFO_R_INC, FIFO_BLOCK, FIFO_RST,
             PAIR_VALID, FRAME_DONE, BUSY, FRAME_CNT
   );

   modport slave (
      output ABORT, S_VALID, FIFO_WR_FULL, FIFO_R_EMPTY, PAIR_READY,
      input  S_READY, FIFO_WR_INC, FIFO_R_INC, FIFO_BLOCK, FIFO_RST,
             PAIR_VALID, FRAME_DONE, BUSY, FRAME_CNT
   );
endinterface

// File: rtl/in_fft_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// in_fft_fifo_ctrl
// Frame sequencer for the iterative-FFT input FIFO. Loads N = 2^AWL samples in
// write mode, flips the FIFO to block (pair-read) mode, issues N/2 pair reads
// to the butterfly engine, pulses FRAME_DONE and returns to loading.
// Ports:
//   WR_CLK : clock for all logic
//   R_RST  : synchronous active-high reset
//   bus    : master modport of in_fft_fifo_ctrl_if (handshakes, FIFO control,
//            frame status)
// S_READY / FIFO_WR_INC / FIFO_R_INC are combinational; all other outputs are
// registered.
// -----------------------------------------------------------------------------
module in_fft_fifo_ctrl #(
   parameter int AWL = 8,
   parameter int FCW = 16
) (
   input  logic                 WR_CLK,
   input  logic                 R_RST,
   in_fft_fifo_ctrl_if.master   bus
);
   typedef enum logic [1:0] {S_LOAD, S_SWITCH, S_DRAIN, S_FLUSH} state_t;

   state_t         r_state, w_state_nxt;
   logic [AWL-1:0] r_wr_cnt, w_wr_cnt_nxt;
   logic [AWL-2:0] r_pair_cnt;
   logic           r_block, r_pair_valid, r_frame_done, r_busy, r_abort;
   logic [FCW-1:0] r_frame_cnt;
   logic           w_s_ready, w_wr_inc, w_r_inc, w_last_wr, w_last_pair;

   // ---------------- state register ----------------
   always_ff @(posedge WR_CLK) begin
      if (R_RST) r_state <= S_LOAD;
      else       r_state <= w_state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD:   if (w_last_wr)   w_state_nxt = S_SWITCH;
         S_SWITCH:                  w_state_nxt = S_DRAIN;
         S_DRAIN:  if (w_last_pair) w_state_nxt = S_FLUSH;
         S_FLUSH:                   w_state_nxt = S_LOAD;
         default:                   w_state_nxt = S_LOAD;
      endcase
      // abort beats a coincident final sample / final pair: frame is dropped
      if (bus.ABORT) w_state_nxt = S_LOAD;
   end

   // ---------------- combinational outputs ----------------
   always_comb begin
      // r_abort marks the FIFO-reset cycle; no sample may land in it
      w_s_ready   = (r_state == S_LOAD) && !bus.FIFO_WR_FULL && !r_abort && !R_RST;
      w_wr_inc    = w_s_ready && bus.S_VALID;
      w_r_inc     = (r_state == S_DRAIN) && bus.PAIR_READY && !bus.FIFO_R_EMPTY && !R_RST;
      w_last_wr   = w_wr_inc && (r_wr_cnt == '1);
      w_last_pair = w_r_inc && (r_pair_cnt == '1);
      // counter wraps to 0 on the last sample by natural overflow
      w_wr_cnt_nxt = r_wr_cnt + AWL'(w_wr_inc);
   end

   // ---------------- counters and registered outputs ----------------
   always_ff @(posedge WR_CLK) begin
      if (R_RST) begin
         r_wr_cnt     <= '0;
         r_pair_cnt   <= '0;
         r_block      <= 1'b0;
         r_pair_valid <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
         r_busy       <= 1'b0;
         r_abort      <= 1'b0;
      end else begin
         r_abort <= bus.ABORT;
         if (bus.ABORT) begin
            r_wr_cnt     <= '0;
            r_pair_cnt   <= '0;
            r_block      <= 1'b0;
            r_pair_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
         end else begin
            r_wr_cnt     <= w_wr_cnt_nxt;
            r_pair_cnt   <= r_pair_cnt + (AWL-1)'(w_r_inc);
            // block mode held from SWITCH through FLUSH
            r_block      <= (w_state_nxt != S_LOAD);
            // FIFO read data appears one cycle after the strobe
            r_pair_valid <= w_r_inc;
            // entering FLUSH: done pulse and count land together
            r_frame_done <= w_last_pair;
            if (w_last_pair) r_frame_cnt <= r_frame_cnt + FCW'(1);
            r_busy       <= (w_state_nxt != S_LOAD) || (w_wr_cnt_nxt != '0);
         end
      end
   end

   assign bus.S_READY     = w_s_ready;
   assign bus.FIFO_WR_INC = w_wr_inc;
   assign bus.FIFO_R_INC  = w_r_inc;
   assign bus.FIFO_BLOCK  = r_block;
   assign bus.FIFO_RST    = R_RST | r_abort;
   assign bus.PAIR_VALID  = r_pair_valid;
   assign bus.FRAME_DONE  = r_frame_done;
   assign bus.BUSY        = r_busy;
   assign bus.FRAME_CNT   = r_frame_cnt;

endmodule

// File: tb/tb_in_fft_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_in_fft_fifo_ctrl
// Directed bench for in_fft_fifo_ctrl with AWL=3 (8-sample frames, 4 pairs).
// Cycle numbering: cycle 1 is the first cycle after R_RST is released.
// Inputs change at the falling edge, outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_in_fft_fifo_ctrl;
   localparam int AWL = 3;
   localparam int FCW = 16;

   logic WR_CLK = 1'b0;
   logic R_RST  = 1'b1;
   int   n_cmp  = 0;
   int   n_bad  = 0;

   in_fft_fifo_ctrl_if #(.FCW(FCW)) bus ();

   in_fft_fifo_ctrl #(.AWL(AWL), .FCW(FCW)) dut (
      .WR_CLK (WR_CLK),
      .R_RST  (R_RST),
      .bus    (bus)
   );

   always #5 WR_CLK = ~WR_CLK;

   task automatic cyc;
      @(posedge WR_CLK);
      @(negedge WR_CLK);
   endtask

   task automatic idle_inputs;
      bus.ABORT = 1'b0; bus.S_VALID = 1'b0; bus.FIFO_WR_FULL = 1'b0;
      bus.FIFO_R_EMPTY = 1'b0; bus.PAIR_READY = 1'b0;
   endtask

   task automatic do_reset;
      idle_inputs();
      R_RST = 1'b1;
      cyc(); cyc();
      R_RST = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      bus.S_VALID = 1'b1; bus.PAIR_READY = 1'b1;
      R_RST = 1'b1;
      cyc(); cyc(); #1;
      n_cmp++; if (bus.S_READY !== 1'b0) begin n_bad++; $display("FAIL reset S_READY got=%b exp=0", bus.S_READY); end
      n_cmp++; if (bus.FIFO_WR_INC !== 1'b0) begin n_bad++; $display("FAIL reset WR_INC got=%b exp=0", bus.FIFO_WR_INC); end
      n_cmp++; if (bus.FIFO_R_INC !== 1'b0) begin n_bad++; $display("FAIL reset R_INC got=%b exp=0", bus.FIFO_R_INC); end
      n_cmp++; if (bus.FIFO_RST !== 1'b1) begin n_bad++; $display("FAIL reset FIFO_RST got=%b exp=1", bus.FIFO_RST); end
      n_cmp++; if ({bus.FIFO_BLOCK, bus.PAIR_VALID, bus.FRAME_DONE, bus.BUSY} !== 4'b0000) begin
         n_bad++; $display("FAIL reset regs got=%b exp=0000", {bus.FIFO_BLOCK, bus.PAIR_VALID, bus.FRAME_DONE, bus.BUSY}); end
      n_cmp++; if (bus.FRAME_CNT !== 16'd0) begin n_bad++; $display("FAIL reset FRAME_CNT got=%0d exp=0", bus.FRAME_CNT); end
   endtask

   // {WR_INC, R_INC, BLOCK, PAIR_VALID, FRAME_DONE, BUSY} per cycle
   task automatic test_stream;
      logic [5:0] e, g;
      do_reset();
      bus.S_VALID = 1'b1; bus.PAIR_READY = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         #1;
         e = {c <= 8, c >= 10 && c <= 13, c >= 9, c >= 11, c == 14, c >= 2};
         g = {bus.FIFO_WR_INC, bus.FIFO_R_INC, bus.FIFO_BLOCK, bus.PAIR_VALID, bus.FRAME_DONE, bus.BUSY};
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL stream c=%0d got=%b exp=%b", c, g, e); end
         n_cmp++; if (bus.FRAME_CNT !== ((c >= 14) ? 16'd1 : 16'd0)) begin
            n_bad++; $display("FAIL stream_cnt c=%0d got=%0d", c, bus.FRAME_CNT); end
         cyc();
      end
      #1;
      // cycle 15: back in LOAD, next frame accepted immediately
      n_cmp++; if ({bus.S_READY, bus.FIFO_BLOCK, bus.BUSY} !== 3'b100) begin
         n_bad++; $display("FAIL stream_reload got=%b exp=100", {bus.S_READY, bus.FIFO_BLOCK, bus.BUSY}); end
   endtask

   task automatic test_gaps;
      int acc = 0, viol = 0, first = 0, acc_at = 0;
      do_reset();
      for (int c = 1; c <= 24; c++) begin
         bus.S_VALID = (c % 2 == 1);
         #1;
         if (bus.FIFO_WR_INC) acc++;
         if (bus.FIFO_WR_INC && !bus.S_VALID) viol++;
         if (bus.FIFO_BLOCK && first == 0) begin first = c; acc_at = acc; end
         cyc();
      end
      n_cmp++; if (acc_at !== 8) begin n_bad++; $display("FAIL gaps_accepted got=%0d exp=8", acc_at); end
      n_cmp++; if (first !== 16) begin n_bad++; $display("FAIL gaps_switch_cycle got=%0d exp=16", first); end
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL gaps_wrinc_no_valid got=%0d exp=0", viol); end
   endtask

   // {R_INC, PAIR_VALID, FRAME_DONE}
   task automatic test_sink_stall;
      logic [2:0] e, g;
      int pairs = 0;
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         bus.S_VALID = (c <= 8);
         bus.PAIR_READY = !(c >= 12 && c <= 14);
         #1;
         if (bus.FIFO_R_INC) pairs++;
         e = {c == 10 || c == 11 || c == 15 || c == 16, c == 11 || c == 12 || c == 16 || c == 17, c == 17};
         g = {bus.FIFO_R_INC, bus.PAIR_VALID, bus.FRAME_DONE};
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL sink_stall c=%0d got=%b exp=%b", c, g, e); end
         cyc();
      end
      n_cmp++; if (pairs !== 4) begin n_bad++; $display("FAIL sink_stall_pairs got=%0d exp=4", pairs); end
      n_cmp++; if (bus.FRAME_CNT !== 16'd1) begin n_bad++; $display("FAIL sink_stall_cnt got=%0d exp=1", bus.FRAME_CNT); end
   endtask

   task automatic test_empty_stall;
      logic [2:0] e, g;
      do_reset();
      bus.PAIR_READY = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         bus.S_VALID = (c <= 8);
         bus.FIFO_R_EMPTY = (c >= 10 && c <= 13);
         #1;
         e = {c >= 14 && c <= 17, c >= 15 && c <= 18, c == 18};
         g = {bus.FIFO_R_INC, bus.PAIR_VALID, bus.FRAME_DONE};
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL empty_stall c=%0d got=%b exp=%b", c, g, e); end
         cyc();
      end
   endtask

   // {S_READY, WR_INC, FIFO_RST, BLOCK, FRAME_DONE, BUSY}
   task automatic test_abort_load;
      logic [5:0] e, g;
      do_reset();
      bus.PAIR_READY = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         bus.S_VALID = (c != 6 && c <= 15);
         bus.ABORT = (c == 6);
         #1;
         e = {(c <= 6) || (c >= 8 && c <= 15) || c == 22, c <= 5 || (c >= 8 && c <= 15), c == 7,
              c >= 16 && c <= 21, c == 21, (c >= 2 && c <= 6) || (c >= 9 && c <= 21)};
         g = {bus.S_READY, bus.FIFO_WR_INC, bus.FIFO_RST, bus.FIFO_BLOCK, bus.FRAME_DONE, bus.BUSY};
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL abort_load c=%0d got=%b exp=%b", c, g, e); end
         n_cmp++; if (bus.FRAME_CNT !== ((c >= 21) ? 16'd1 : 16'd0)) begin
            n_bad++; $display("FAIL abort_load_cnt c=%0d got=%0d", c, bus.FRAME_CNT); end
         cyc();
      end
      bus.ABORT = 1'b0;
   endtask

   // {S_READY, R_INC, PAIR_VALID, FIFO_RST, BLOCK, FRAME_DONE}
   task automatic test_abort_drain;
      logic [5:0] e, g;
      do_reset();
      for (int c = 1; c <= 28; c++) begin
         bus.S_VALID = (c <= 8) || (c >= 14 && c <= 21);
         bus.PAIR_READY = (c != 12);
         bus.ABORT = (c == 12);
         #1;
         e = {(c <= 8) || (c >= 14 && c <= 21) || c == 28,
              c == 10 || c == 11 || (c >= 23 && c <= 26),
              c == 11 || c == 12 || (c >= 24 && c <= 27),
              c == 13, (c >= 9 && c <= 12) || (c >= 22 && c <= 27), c == 27};
         g = {bus.S_READY, bus.FIFO_R_INC, bus.PAIR_VALID, bus.FIFO_RST, bus.FIFO_BLOCK, bus.FRAME_DONE};
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL abort_drain c=%0d got=%b exp=%b", c, g, e); end
         n_cmp++; if (bus.FRAME_CNT !== ((c >= 27) ? 16'd1 : 16'd0)) begin
            n_bad++; $display("FAIL abort_drain_cnt c=%0d got=%0d", c, bus.FRAME_CNT); end
         cyc();
      end
      bus.ABORT = 1'b0;
   endtask

   // abort on the final sample: SWITCH must not happen
   // {S_READY, WR_INC, FIFO_RST, BLOCK, FRAME_DONE, BUSY}
   task automatic test_abort_last;
      logic [5:0] e, g;
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         bus.S_VALID = (c <= 8);
         bus.ABORT = (c == 8);
         #1;
         e = {c <= 8 || c == 10, c <= 8, c == 9, 1'b0, 1'b0, c >= 2 && c <= 8};
         g = {bus.S_READY, bus.FIFO_WR_INC, bus.FIFO_RST, bus.FIFO_BLOCK, bus.FRAME_DONE, bus.BUSY};
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL abort_last c=%0d got=%b exp=%b", c, g, e); end
         cyc();
      end
      bus.ABORT = 1'b0;
   endtask

   // {S_READY, R_INC, PAIR_VALID, FIFO_RST, BLOCK, FRAME_DONE, BUSY}
   task automatic test_rst_drain;
      logic [6:0] e, g;
      do_reset();
      bus.PAIR_READY = 1'b1;
      for (int c = 1; c <= 28; c++) begin
         R_RST = (c == 12 || c == 13);
         bus.S_VALID = (c <= 8) || (c >= 14 && c <= 21);
         #1;
         e = {(c <= 8) || (c >= 14 && c <= 21) || c == 28,
              c == 10 || c == 11 || (c >= 23 && c <= 26),
              c == 11 || c == 12 || (c >= 24 && c <= 27),
              c == 12 || c == 13, (c >= 9 && c <= 12) || (c >= 22 && c <= 27), c == 27,
              (c >= 2 && c <= 12) || (c >= 15 && c <= 27)};
         g = {bus.S_READY, bus.FIFO_R_INC, bus.PAIR_VALID, bus.FIFO_RST, bus.FIFO_BLOCK, bus.FRAME_DONE, bus.BUSY};
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL rst_drain c=%0d got=%b exp=%b", c, g, e); end
         n_cmp++; if (bus.FRAME_CNT !== ((c >= 27) ? 16'd1 : 16'd0)) begin
            n_bad++; $display("FAIL rst_drain_cnt c=%0d got=%0d", c, bus.FRAME_CNT); end
         cyc();
      end
   endtask

   // two frames streamed with no idle cycle between them
   task automatic test_back_to_back;
      logic [1:0] e, g;
      do_reset();
      bus.S_VALID = 1'b1; bus.PAIR_READY = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         #1;
         e = {c <= 8 || (c >= 15 && c <= 22) || c >= 29, c == 14 || c == 28};
         g = {bus.FIFO_WR_INC, bus.FRAME_DONE};
         n_cmp++; if (g !== e) begin n_bad++; $display("FAIL back_to_back c=%0d got=%b exp=%b", c, g, e); end
         n_cmp++; if (bus.FRAME_CNT !== ((c >= 28) ? 16'd2 : (c >= 14) ? 16'd1 : 16'd0)) begin
            n_bad++; $display("FAIL back_to_back_cnt c=%0d got=%0d", c, bus.FRAME_CNT); end
         cyc();
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_stream();
      test_gaps();
      test_sink_stall();
      test_empty_stall();
      test_abort_load();
      test_abort_drain();
      test_abort_last();
      test_rst_drain();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
